// File: rtl/rf_arbiter.sv
// rf_arbiter: two-port round-robin arbiter in front of the 16x8 display
// register file. After reset or a clear request it sweeps every entry to
// zero before granting any access.
//
// Handshake: a port raises {x}_req with we/addr/wdata valid and holds them
// until {x}_gnt is seen high; the transfer happens on the rising edge where
// req and gnt are both high. Reads return {x}_rdata with a one-cycle
// {x}_rvalid pulse in the following cycle.
module rf_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_dout,
    output logic          init_busy
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    // 1 when B holds the most recent grant, so A wins the next tie.
    logic          last_b_q, last_b_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    // Sweep/arbitration decode, datapath mux and next-state computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_b_d   = last_b_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_din     = '0;
        init_busy  = 1'b0;

        if (rst) begin
            // Everything is gated off; the flops are cleared in always_ff.
            init_busy = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // Zeroing sweep: requests and clr_req wait for RUN.
                    init_busy = 1'b1;
                    rf_we     = 1'b1;
                    rf_addr   = cnt_q;
                    cnt_d     = cnt_q + AW'(1);
                    if (cnt_q == {AW{1'b1}}) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (clr_req) begin
                        // Clear beats any request; the request stays pending.
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else begin
                        a_gnt = a_req && (!b_req || last_b_q);
                        b_gnt = b_req && !a_gnt;
                        if (a_gnt) begin
                            rf_we    = a_we;
                            rf_addr  = a_addr;
                            rf_din   = a_wdata;
                            last_b_d = 1'b0;
                            if (!a_we) begin
                                a_rvalid_d = 1'b1;
                                a_rdata_d  = rf_dout;
                            end
                        end else if (b_gnt) begin
                            rf_we    = b_we;
                            rf_addr  = b_addr;
                            rf_din   = b_wdata;
                            last_b_d = 1'b1;
                            if (!b_we) begin
                                b_rvalid_d = 1'b1;
                                b_rdata_d  = rf_dout;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State, sweep counter, fairness pointer and registered read returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: directed scenarios with literal expectations, then a long
// randomized run, all checked every cycle against a behavioural model.
module tb_rf_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          clr_req = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, rf_we, init_busy;
  logic [DW-1:0] a_rdata, b_rdata, rf_din, rf_dout;
  logic [AW-1:0] rf_addr;

  rf_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout),
    .init_busy(init_busy)
  );

  // Register file itself: combinational read, write on rising edge.
  logic [DW-1:0] env_mem [N];
  assign rf_dout = env_mem[rf_addr];
  always @(posedge clk) if (rf_we) env_mem[rf_addr] <= rf_din;

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [N];
  int            m_left;      // sweep cycles still to go (0 = running)
  logic          m_last_b;    // B was granted most recently
  logic          m_arv, m_brv;
  logic [DW-1:0] m_ard, m_brd;
  logic          started = 1'b0;
  logic [1:0]    e_gnt;
  logic          e_we, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  // Compare DUT against the model each cycle, then advance the model.
  always @(negedge clk) begin
    e_gnt = 2'b00; e_we = 1'b0; e_addr = '0; e_din = '0; e_busy = 1'b0;
    if (rst) begin
      e_busy = 1'b1;
    end else if (m_left > 0) begin
      e_busy = 1'b1; e_we = 1'b1; e_addr = AW'(N - m_left);
    end else if (!clr_req) begin
      if (a_req && b_req) e_gnt = m_last_b ? 2'b10 : 2'b01;
      else if (a_req)     e_gnt = 2'b10;
      else if (b_req)     e_gnt = 2'b01;
      if (e_gnt == 2'b10) begin e_we = a_we; e_addr = a_addr; e_din = a_wdata; end
      if (e_gnt == 2'b01) begin e_we = b_we; e_addr = b_addr; e_din = b_wdata; end
    end

    if (started) begin
      check("gnt", {a_gnt, b_gnt}, e_gnt);
      check("rf_we", rf_we, e_we);
      check("init_busy", init_busy, e_busy);
      if (e_we || e_gnt != 2'b00) begin
        check("rf_addr", rf_addr, e_addr);
        check("rf_din", rf_din, e_din);
      end
      check("a_rvalid", a_rvalid, m_arv);
      check("a_rdata", a_rdata, m_ard);
      check("b_rvalid", b_rvalid, m_brv);
      check("b_rdata", b_rdata, m_brd);
    end

    if (rst) begin
      m_left = N; m_last_b = 1'b1;
      m_arv = 1'b0; m_brv = 1'b0; m_ard = '0; m_brd = '0;
      started = 1'b1;
    end else begin
      m_arv = 1'b0; m_brv = 1'b0;
      if (m_left > 0) begin
        m_mem[e_addr] = '0;
        m_left--;
      end else if (clr_req) begin
        m_left = N;
      end else if (e_gnt == 2'b10) begin
        m_last_b = 1'b0;
        if (a_we) m_mem[a_addr] = a_wdata;
        else begin m_arv = 1'b1; m_ard = m_mem[a_addr]; end
      end else if (e_gnt == 2'b01) begin
        m_last_b = 1'b1;
        if (b_we) m_mem[b_addr] = b_wdata;
        else begin m_brv = 1'b1; m_brd = m_mem[b_addr]; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_req = req; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    b_req = req; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  task automatic reset_and_sweep();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (N) tick();
  endtask

  logic [1:0] tie_exp [6];
  logic [1:0] hist_exp [5];
  logic       ga, gb;

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) env_mem[i] = DW'($urandom_range(1, 255));
    tie_exp  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    hist_exp = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    // Reset sweep
    sample();
    check("rst_gnt", {a_gnt, b_gnt}, 2'b00);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_busy", init_busy, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      sample();
      check("sweep_we", rf_we, 1'b1);
      check("sweep_addr", rf_addr, i);
      check("sweep_din", rf_din, 8'h00);
      check("sweep_busy", init_busy, 1'b1);
      if (i == 0) check("rst_a_rdata", {a_rvalid, a_rdata}, 9'h000);
      tick();
    end
    set_a(1'b1, 1'b0, 4'd5, 8'h00);
    sample();
    check("run_busy", init_busy, 1'b0);
    check("first_gnt", a_gnt, 1'b1);
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    sample();
    check("rd5_valid", a_rvalid, 1'b1);
    check("rd5_data", a_rdata, 8'h00);
    tick();

    // Write then read
    set_a(1'b1, 1'b1, 4'd7, 8'h3C);
    sample(); check("wr7_gnt", a_gnt, 1'b1);
    tick();
    set_a(1'b1, 1'b0, 4'd7, 8'h00);
    sample(); check("rd7_gnt", a_gnt, 1'b1);
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    sample();
    check("rd7_valid", a_rvalid, 1'b1);
    check("rd7_data", a_rdata, 8'h3C);
    tick();
    sample();
    check("rd7_valid_drop", a_rvalid, 1'b0);
    check("rd7_hold", a_rdata, 8'h3C);
    tick();

    // One B access so the pointer favours A, then a 6-cycle tie
    set_b(1'b1, 1'b0, 4'd1, 8'h00);
    sample(); check("pre_tie_b", b_gnt, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 1'b0, AW'($urandom_range(0, N - 1)), 8'h00);
      set_b(1'b1, 1'b0, AW'($urandom_range(0, N - 1)), 8'h00);
      sample();
      check("tie_seq", {a_gnt, b_gnt}, tie_exp[i]);
      tick();
    end

    // Pointer history: B alone x3, then both x2
    for (int i = 0; i < 5; i++) begin
      set_a(i >= 3, 1'b1, AW'(10 + i), DW'($urandom));
      set_b(1'b1, 1'b1, AW'(i), DW'($urandom));
      sample();
      check("hist_seq", {a_gnt, b_gnt}, hist_exp[i]);
      tick();
    end
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    set_b(1'b0, 1'b0, 4'd0, 8'h00);

    // Clear sweep
    set_a(1'b1, 1'b1, 4'd0, 8'hFF); tick();
    set_a(1'b1, 1'b1, 4'd15, 8'hFF); tick();
    set_a(1'b1, 1'b0, 4'd0, 8'h00);
    clr_req = 1'b1;
    sample(); check("clr_no_gnt", a_gnt, 1'b0);
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      sample();
      check("clr_hold_gnt", a_gnt, 1'b0);
      tick();
    end
    sample(); check("clr_after_gnt", a_gnt, 1'b1);
    tick();
    set_a(1'b1, 1'b0, 4'd15, 8'h00);
    sample();
    check("clr_rd0", {a_rvalid, a_rdata}, 9'h100);
    check("clr_rd15_gnt", a_gnt, 1'b1);
    tick();
    set_a(1'b0, 1'b0, 4'd0, 8'h00);
    sample(); check("clr_rd15", {a_rvalid, a_rdata}, 9'h100);
    tick();

    // Reset at sweep address 9
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (9) tick();
    sample(); check("pre_int_addr", rf_addr, 4'd9);
    rst = 1'b1;
    sample(); check("int_rf_we", rf_we, 1'b0);
    tick();
    rst = 1'b0;
    sample();
    check("restart_addr", rf_addr, 4'd0);
    check("restart_we", rf_we, 1'b1);
    repeat (N) tick();

    // Reset right after a B read grant
    set_b(1'b1, 1'b1, 4'd3, 8'hA5);
    sample(); check("b_wr_gnt", b_gnt, 1'b1);
    tick();
    set_b(1'b1, 1'b0, 4'd3, 8'h00);
    sample(); check("b_rd_gnt", b_gnt, 1'b1);
    tick();
    set_b(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(); check("b_lost_read", {b_rvalid, b_rdata}, 9'h000);
    repeat (N) tick();

    // Randomized traffic; requests held until granted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ga = a_gnt; gb = b_gnt;
      tick();
      rst     = ($urandom_range(0, 399) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      if (!a_req || ga)
        set_a($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, N - 1)), DW'($urandom));
      if (!b_req || gb)
        set_b($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, N - 1)), DW'($urandom));
    end
    rst = 1'b0; clr_req = 1'b0;
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_arbiter.md
# rf_arbiter

Two-port arbiter and initialiser for the 16×8 single-port register file that feeds the seven-segment display path. It gives two requesters shared access to the register file, typically the switch/key user port and an auto-scan or debug port. After reset or a clear request, it sweeps the register file and writes zero to every entry. Grants use a request/grant handshake with round-robin fairness, and read data returns registered one cycle after the grant.

## Interface
- AW, 4, register-file address width; the sweep covers 2^AW entries.
- DW, 8, register-file data width.

- clk  in  1  single clock; the register file writes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  single-cycle pulse that restarts the zeroing sweep.
- a_req / b_req  in  1  access request; held high until granted.
- a_we / b_we  in  1  1 = write, 0 = read; valid while req is high.
- a_addr / b_addr  in  AW  target address.
- a_wdata / b_wdata  in  DW  write data.
- a_gnt / b_gnt  out  1  combinational grant; the transfer occurs on the edge where req and gnt are both high.
- a_rvalid / b_rvalid  out  1  registered one-cycle pulse; read data is valid.
- a_rdata / b_rdata  out  DW  registered read data; holds until that port's next read completes.
- rf_we  out  1  register-file write enable.
- rf_addr  out  AW  register-file address.
- rf_din  out  DW  register-file write data.
- rf_dout  in  DW  register-file read data; combinational from rf_addr.
- init_busy  out  1  high while reset is asserted or a sweep is in progress.

## Operation
- States: INIT and RUN. A cycle with rst high forces INIT with sweep counter 0.
- INIT behaviour:
  - Each cycle drives rf_we=1, rf_addr=counter and rf_din=0, then increments the counter.
  - After the cycle with address 2^AW−1, the state moves to RUN.
  - No grants are issued; requests stay pending.
  - clr_req is ignored.
- RUN behaviour:
  - clr_req=1 moves to INIT with counter 0 and issues no grant in that cycle. clr_req takes priority over requests.
  - Only one req high: that port is granted.
  - Both req high: the port not granted most recently wins.
  - The last-grant pointer updates only on a grant. Its reset value is B, so A wins the first tie.
- Datapath mux: rf_addr and rf_din come from the granted port. rf_we = granted port's we. With no grant: rf_we=0, rf_addr=0, rf_din=0.
- Read completion: on a granted read edge, {x}_rdata ← rf_dout and {x}_rvalid ← 1 for one cycle. The other port's rdata and rvalid are unaffected.
- Write completion: the write commits at the grant edge. A read of the same address in any later cycle returns the new value.
- At most one access per cycle. A single port can be granted on consecutive cycles if the other port is idle.

## Timing
- Reset values, set at the edge with rst=1:
  - state=INIT, counter=0, pointer=B.
  - a_rvalid=b_rvalid=0 and a_rdata=b_rdata=0.
- Combinational outputs while rst is high: a_gnt=b_gnt=0, rf_we=0, init_busy=1.
- After rst falls: INIT occupies exactly 2^AW cycles, writing address 0..15 in order. init_busy is 1 throughout and drops to 0 in the first RUN cycle. The first grant is possible in cycle 2^AW after rst deasserts.
- Grant latency: zero cycles (combinational from req in RUN).
- Read latency: rvalid/rdata appear in the cycle after the grant.
- Reset mid-INIT: the sweep restarts at address 0.
- Reset mid-read, meaning rst high in the cycle after a grant edge: rvalid=0 and rdata=0; the read is lost.
- clr_req in the same cycle as a request: the request is not granted and stays pending until the sweep ends.
- A rvalid already scheduled from the previous cycle's grant still pulses on the cycle clr_req enters INIT.

## Test plan
- Reset sweep:
  - Stimulus: rst high for 1 cycle, then low.
  - Required: 16 cycles of rf_we=1, rf_din=0x00, rf_addr 0→15; init_busy falls in cycle 16. An A read of address 5 then gives a_rvalid one cycle later with a_rdata=0x00.
- Write then read:
  - Stimulus: A writes 0x3C to address 7, then reads address 7 on the next cycle.
  - Required: a_gnt is high both cycles, and a_rvalid is high the cycle after the read with a_rdata=0x3C. The value stays unchanged after rvalid drops.
- Tie fairness:
  - Stimulus: a_req and b_req held high for 6 cycles.
  - Required: grant sequence A,B,A,B,A,B, with exactly one gnt high per cycle.
- Pointer history:
  - Stimulus: only B requests for 3 cycles, then both request for 2 cycles.
  - Required: grant sequence B,B,B,A,B.
- Clear sweep:
  - Stimulus: after writing 0xFF to addresses 0 and 15, pulse clr_req while A requests.
  - Required: a_gnt=0 for 16 cycles, then A is granted. Reads of addresses 0 and 15 return 0x00.
- Reset interruptions:
  - Stimulus: rst asserted when the sweep is at address 9.
  - Required: the next sweep starts at address 0. Asserting rst the cycle after a B read grant forces b_rvalid=0 and b_rdata=0x00.
